// File: rtl/soc_system_hex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_hex_ctrl
//  Description : Avalon-MM controller for NUM_DIGITS active-low seven-segment
//                digits. Each digit shows either a raw segment pattern or a
//                decoded hex nibble, and can blink under a programmable
//                prescaler. A packed HEX_VALUE write updates all digits at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_hex_ctrl #(
   parameter int         NUM_DIGITS    = 6,
   parameter logic [6:0] RESET_PATTERN = 7'h3F,
   parameter int         DIV_W         = 24
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [3:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [NUM_DIGITS*7-1:0] out_port
);

   // Word addresses of the non-digit registers
   localparam logic [3:0] c_ADDR_DECODE_EN = 4'd8;
   localparam logic [3:0] c_ADDR_BLINK_EN  = 4'd9;
   localparam logic [3:0] c_ADDR_BLINK_DIV = 4'd10;
   localparam logic [3:0] c_ADDR_STATUS    = 4'd11;
   localparam logic [3:0] c_ADDR_HEX_VALUE = 4'd12;

   // Blink half-period after reset: 2**(DIV_W-1) cycles
   localparam logic [DIV_W-1:0] c_DIV_RESET = {1'b1, {(DIV_W-1){1'b0}}};
   localparam logic [6:0]       c_SEG_BLANK = 7'h7F;

   // Nibble to active-low glyph, bit 6 = segment g
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Bus strobes
   logic w_wr_en;
   logic w_wr_decode;
   logic w_wr_blink;
   logic w_wr_div;
   logic w_wr_hex;

   // Register state
   logic [6:0]            digit_q [NUM_DIGITS];
   logic [6:0]            digit_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] decode_en_q;
   logic [NUM_DIGITS-1:0] decode_en_d;
   logic [NUM_DIGITS-1:0] blink_en_q;
   logic [NUM_DIGITS-1:0] blink_en_d;
   logic [DIV_W-1:0]      blink_div_q;
   logic [DIV_W-1:0]      blink_div_d;
   logic [DIV_W-1:0]      cnt_q;
   logic [DIV_W-1:0]      cnt_d;
   logic                  phase_q;
   logic                  phase_d;

   // Output path
   logic [NUM_DIGITS*7-1:0] w_out;
   logic [NUM_DIGITS*7-1:0] out_q;

   // Upper write-data bits have no home in narrow configurations
   logic w_unused_wdata;
   assign w_unused_wdata = ^writedata;

   assign w_wr_en     = chipselect & ~write_n;
   assign w_wr_decode = w_wr_en && (address == c_ADDR_DECODE_EN);
   assign w_wr_blink  = w_wr_en && (address == c_ADDR_BLINK_EN);
   assign w_wr_div    = w_wr_en && (address == c_ADDR_BLINK_DIV);
   assign w_wr_hex    = w_wr_en && (address == c_ADDR_HEX_VALUE);

   // Digit next-state: per-digit write, or nibble unpacking from HEX_VALUE
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_d[i] = digit_q[i];
         if (w_wr_en && (address == 4'(i))) begin
            digit_d[i] = writedata[6:0];
         end else if (w_wr_hex) begin
            digit_d[i] = {3'b000, writedata[4*i +: 4]};
         end
      end
   end

   // Control register next-state; HEX_VALUE also switches every digit to decode
   always_comb begin
      decode_en_d = decode_en_q;
      blink_en_d  = blink_en_q;
      blink_div_d = blink_div_q;
      if (w_wr_decode) begin
         decode_en_d = writedata[NUM_DIGITS-1:0];
      end else if (w_wr_hex) begin
         decode_en_d = '1;
      end
      if (w_wr_blink) begin
         blink_en_d = writedata[NUM_DIGITS-1:0];
      end
      if (w_wr_div) begin
         blink_div_d = writedata[DIV_W-1:0];
      end
   end

   // Prescaler: a BLINK_DIV write restarts the period in the on phase and
   // takes priority over a coincident terminal count
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (w_wr_div) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (blink_div_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == (blink_div_q - DIV_W'(1))) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + DIV_W'(1);
      end
   end

   // Per-digit segment selection and blanking during the off phase
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_out
      logic [6:0] w_seg;
      assign w_seg = decode_en_q[gi] ? hex_decode(digit_q[gi][3:0]) : digit_q[gi];
      assign w_out[gi*7 +: 7] = (blink_en_q[gi] && !phase_q) ? c_SEG_BLANK : w_seg;
   end

   // Digit storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= RESET_PATTERN;
         end
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= digit_d[i];
         end
      end
   end

   // Control registers and prescaler state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decode_en_q <= '0;
         blink_en_q  <= '0;
         blink_div_q <= c_DIV_RESET;
         cnt_q       <= '0;
         phase_q     <= 1'b1;
      end else begin
         decode_en_q <= decode_en_d;
         blink_en_q  <= blink_en_d;
         blink_div_q <= blink_div_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
      end
   end

   // Registered pin drive: glitch-free HEX outputs, one cycle behind state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= {NUM_DIGITS{RESET_PATTERN}};
      end else begin
         out_q <= w_out;
      end
   end

   assign out_port = out_q;

   // Zero-latency read mux; unimplemented addresses and bits read 0
   always_comb begin
      readdata = '0;
      if (address < c_ADDR_DECODE_EN) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(i)) begin
               readdata = {25'd0, digit_q[i]};
            end
         end
      end else begin
         case (address)
            c_ADDR_DECODE_EN: readdata[NUM_DIGITS-1:0] = decode_en_q;
            c_ADDR_BLINK_EN:  readdata[NUM_DIGITS-1:0] = blink_en_q;
            c_ADDR_BLINK_DIV: readdata[DIV_W-1:0]      = blink_div_q;
            c_ADDR_STATUS:    readdata[0]              = phase_q;
            default:          readdata                 = '0;
         endcase
      end
   end

endmodule
`default_nettype wire
